// File: rtl/timer_multi.sv
// Minute:second run timer that counts up or down, with pause, clear, auto-reload and an expiry pulse.
// Latency: START loads the counter at its own edge; the first count change comes TICK_DIV edges later.
// No backpressure: commands act on the next SYSCLK edge with priority CLEAR > START > PAUSE.
module timer_multi #(
  parameter int MIN_W    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             SYSCLK,
  input  logic             RST_B,
  input  logic [MIN_W-1:0] TIME_MIN,
  input  logic [5:0]       TIME_SEC,
  input  logic             MODE,
  input  logic             AUTO_RELOAD,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             CLEAR,
  output logic [MIN_W-1:0] MINUTE,
  output logic [5:0]       SECOND,
  output logic             RUNNING,
  output logic             TIME_UP,
  output logic             DONE
);

  // Prescaler width; a TICK_DIV of 1 still keeps one (always-zero) bit.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [MIN_W-1:0] tgt_min;
  logic [5:0]       tgt_sec;
  logic             mode_q;
  // Set after an auto-reload expiry: the next tick reloads the start value
  // instead of stepping past the terminal value.
  logic             reload_pend;
  // Set when START loaded a value that is already terminal (target 0:00);
  // the expiry then fires on the very next edge, independent of the prescaler.
  logic             arm;

  logic             tick;
  logic [PW-1:0]    presc_nxt;
  logic [5:0]       sec_in;
  logic             in_zero;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic [MIN_W-1:0] term_min;
  logic [5:0]       term_sec;
  logic [MIN_W-1:0] step_min;
  logic [5:0]       step_sec;
  logic             step_term;

  // Prescaler wrap, input clamp, start/terminal values and the next counter value on a tick.
  always_comb begin
    tick      = (presc == PMAX);
    presc_nxt = tick ? '0 : presc + 1'b1;

    sec_in  = (TIME_SEC > 6'd59) ? 6'd59 : TIME_SEC;
    in_zero = (TIME_MIN == '0) && (sec_in == 6'd0);

    // Up runs start at 0:00 and end at the target; down runs the reverse.
    load_min = mode_q ? tgt_min : '0;
    load_sec = mode_q ? tgt_sec : 6'd0;
    term_min = mode_q ? '0 : tgt_min;
    term_sec = mode_q ? 6'd0 : tgt_sec;

    step_min = MINUTE;
    step_sec = SECOND;
    if (reload_pend) begin
      step_min = load_min;
      step_sec = load_sec;
    end else if (!mode_q) begin
      if (SECOND == 6'd59) begin
        step_sec = 6'd0;
        step_min = MINUTE + 1'b1;
      end else begin
        step_sec = SECOND + 6'd1;
      end
    end else begin
      if (SECOND == 6'd0) begin
        step_sec = 6'd59;
        step_min = MINUTE - 1'b1;
      end else begin
        step_sec = SECOND - 6'd1;
      end
    end

    step_term = (step_min == term_min) && (step_sec == term_sec);
  end

  // Control FSM with registered counter and status outputs.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state       <= IDLE;
      presc       <= '0;
      tgt_min     <= '0;
      tgt_sec     <= 6'd0;
      mode_q      <= 1'b0;
      reload_pend <= 1'b0;
      arm         <= 1'b0;
      MINUTE      <= '0;
      SECOND      <= 6'd0;
      RUNNING     <= 1'b0;
      TIME_UP     <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      TIME_UP <= 1'b0;
      if (CLEAR) begin
        state       <= IDLE;
        presc       <= '0;
        reload_pend <= 1'b0;
        arm         <= 1'b0;
        MINUTE      <= '0;
        SECOND      <= 6'd0;
        RUNNING     <= 1'b0;
        DONE        <= 1'b0;
      end else if (START) begin
        state       <= RUN;
        presc       <= '0;
        tgt_min     <= TIME_MIN;
        tgt_sec     <= sec_in;
        mode_q      <= MODE;
        reload_pend <= 1'b0;
        arm         <= in_zero;
        MINUTE      <= MODE ? TIME_MIN : '0;
        SECOND      <= MODE ? sec_in : 6'd0;
        RUNNING     <= 1'b1;
        DONE        <= 1'b0;
      end else begin
        case (state)
          RUN, PAUSED: begin
            if (PAUSE) begin
              // Freeze counter and prescaler exactly where they are.
              state   <= PAUSED;
              RUNNING <= 1'b0;
            end else begin
              // Leaving PAUSED counts on this same edge, so no cycle is lost.
              state   <= RUN;
              RUNNING <= 1'b1;
              presc   <= presc_nxt;
              if (arm || (tick && step_term)) begin
                if (!arm) begin
                  MINUTE <= step_min;
                  SECOND <= step_sec;
                end
                arm         <= 1'b0;
                TIME_UP     <= 1'b1;
                reload_pend <= AUTO_RELOAD;
                if (!AUTO_RELOAD) begin
                  state   <= FIN;
                  RUNNING <= 1'b0;
                  DONE    <= 1'b1;
                end
              end else if (tick) begin
                MINUTE      <= step_min;
                SECOND      <= step_sec;
                reload_pend <= 1'b0;
              end
            end
          end
          default: begin
            // IDLE and FIN hold until START or CLEAR; PAUSE is ignored here.
          end
        endcase
      end
    end
  end

endmodule
